// File: rtl/countdown_display.sv
// Converts each new count_in value to BCD with a serial double-dabble FSM, flags zero/wrap
// events, and drives a time-multiplexed two-digit seven-segment display.
module countdown_display #(
    parameter int WIDTH          = 5,
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             busy,
    output logic             zero_pulse,
    output logic             wrap_pulse,
    output logic [6:0]       seg,
    output logic [1:0]       digit_en
);

    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_last_count;
    logic [WIDTH-1:0]   r_bin;
    logic [7:0]         r_bcd;
    logic [ITER_W-1:0]  r_iter;
    logic               r_sat;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic               r_zero_pulse;
    logic               r_wrap_pulse;
    logic [REF_W-1:0]   r_refresh;
    logic               r_digit_sel;

    logic               w_capture;
    logic               w_last_iter;
    logic               w_over;
    logic [7:0]         w_bcd_adj;
    logic [WIDTH+7:0]   w_shift;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg;
    logic [1:0]         w_digit_en;

    // Values above 31 only exist for wider counters; they saturate to "31".
    if (WIDTH > 5) begin : g_sat
        assign w_over = |count_in[WIDTH-1:5];
    end else begin : g_nosat
        assign w_over = 1'b0;
    end

    assign w_capture   = (r_state == IDLE) && (count_in != r_last_count);
    assign w_last_iter = (r_iter == ITER_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_next_state = SHIFT;
            SHIFT:   if (w_last_iter) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_shift        = {w_bcd_adj, r_bin} << 1;
    end

    // NOTE: the scratch registers are small flops, not RAM, so they are reset along with the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_count <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_iter       <= '0;
            r_sat        <= 1'b0;
            r_tens       <= '0;
            r_ones       <= '0;
            r_zero_pulse <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_zero_pulse <= w_capture && (count_in == '0);
            r_wrap_pulse <= w_capture && (count_in == MAX_COUNT) && (r_last_count == '0);
            if (w_capture) begin
                r_last_count <= count_in;
                r_bin        <= count_in;
                r_bcd        <= '0;
                r_iter       <= '0;
                r_sat        <= w_over;
            end else if (r_state == SHIFT) begin
                r_bcd  <= w_shift[WIDTH+7:WIDTH];
                r_bin  <= w_shift[WIDTH-1:0];
                r_iter <= r_iter + ITER_W'(1);
            end else if (r_state == DONE) begin
                r_tens <= r_sat ? 4'd3 : r_bcd[7:4];
                r_ones <= r_sat ? 4'd1 : r_bcd[3:0];
            end
        end
    end

    // Display refresh runs freely, independent of the conversion FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh   <= '0;
            r_digit_sel <= 1'b0;
        end else if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
            r_refresh   <= '0;
            r_digit_sel <= ~r_digit_sel;
        end else begin
            r_refresh <= r_refresh + REF_W'(1);
        end
    end

    always_comb begin
        w_digit    = r_digit_sel ? r_tens : r_ones;
        w_digit_en = r_digit_sel ? 2'b10 : 2'b01;
        case (w_digit)
            4'd0:    w_seg = 7'b0111111;
            4'd1:    w_seg = 7'b0000110;
            4'd2:    w_seg = 7'b1011011;
            4'd3:    w_seg = 7'b1001111;
            4'd4:    w_seg = 7'b1100110;
            4'd5:    w_seg = 7'b1101101;
            4'd6:    w_seg = 7'b1111101;
            4'd7:    w_seg = 7'b0000111;
            4'd8:    w_seg = 7'b1111111;
            4'd9:    w_seg = 7'b1101111;
            default: w_seg = 7'b0000000;
        endcase
    end

    assign tens       = r_tens;
    assign ones       = r_ones;
    assign busy       = (r_state != IDLE);
    assign zero_pulse = r_zero_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign seg        = w_seg ^ {7{SEG_ACTIVE_LOW}};
    assign digit_en   = w_digit_en ^ {2{SEG_ACTIVE_LOW}};

endmodule
